// File: rtl/ctrl_seq_pkg.sv
// Shared types, default micro-table and lookup helper for the ctrl_sequencer slice.
// The optional illegal-opcode trap is selected by CTRL_SEQ_TRAP_EN in ctrl_sequencer.sv.
package ctrl_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam int unsigned UC_CW_W = 8;

    typedef struct packed {
        logic               last;
        logic [UC_CW_W-1:0] word;
    } ucode_entry_t;

    // Step 0 of each opcode is the word the old single-cycle decoder produced.
    localparam logic [UC_CW_W-1:0] UC_OP0_S0 = 8'hC1;
    localparam logic [UC_CW_W-1:0] UC_OP1_S0 = 8'h6A;
    localparam logic [UC_CW_W-1:0] UC_OP1_S1 = 8'h2A;
    localparam logic [UC_CW_W-1:0] UC_OP2_S0 = 8'hA4;
    localparam logic [UC_CW_W-1:0] UC_OP2_S1 = 8'h24;
    localparam logic [UC_CW_W-1:0] UC_OP2_S2 = 8'h04;
    localparam logic [UC_CW_W-1:0] UC_OP3_S0 = 8'h12;

    function automatic int unsigned step_w(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic ucode_entry_t ucode_lookup(input int unsigned op, input int unsigned stp);
        ucode_entry_t e;
        e.last = 1'b1;
        e.word = '0;
        case (op)
            0: e.word = UC_OP0_S0;
            1: begin
                case (stp)
                    0: begin
                        e.last = 1'b0;
                        e.word = UC_OP1_S0;
                    end
                    default: e.word = UC_OP1_S1;
                endcase
            end
            2: begin
                case (stp)
                    0: begin
                        e.last = 1'b0;
                        e.word = UC_OP2_S0;
                    end
                    1: begin
                        e.last = 1'b0;
                        e.word = UC_OP2_S1;
                    end
                    default: e.word = UC_OP2_S2;
                endcase
            end
            3: e.word = UC_OP3_S0;
            default: begin
                e.last = 1'b1;
                e.word = '0;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ctrl_seq_rom.sv
// Combinational micro-code ROM: {op, step} -> {last, word}.
// Swap this module for a custom table; opcodes at or above NUM_OPS read as a single zero step.
module ctrl_seq_rom
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned OPC_W   = 2,
    parameter int unsigned CW_W    = 8,
    parameter int unsigned STEPS   = 4,
    parameter int unsigned NUM_OPS = 4
) (
    input  logic [OPC_W-1:0]          op,
    input  logic [step_w(STEPS)-1:0]  step,
    output logic                      last,
    output logic [CW_W-1:0]           word
);

    ucode_entry_t entry;

    always_comb begin
        entry = ucode_lookup(32'(op), 32'(step));
        if (32'(op) >= NUM_OPS) begin
            last = 1'b1;
            word = '0;
        end else begin
            last = entry.last;
            word = CW_W'(entry.word);
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-step micro-program sequencer with valid/ready issue, stall and back-to-back dispatch.
// Define CTRL_SEQ_TRAP_EN to trap opcodes at or above NUM_OPS and raise the sticky illegal flag.
module ctrl_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned OPC_W   = 2,
    parameter int unsigned CW_W    = 8,
    parameter int unsigned STEPS   = 4,
    parameter int unsigned NUM_OPS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [OPC_W-1:0]          opcode,
    input  logic                      stall,
    output logic [CW_W-1:0]           ctrl,
    output logic                      ctrl_valid,
    output logic [step_w(STEPS)-1:0]  step,
    output logic                      done,
    output logic                      illegal
);

    localparam int unsigned SW = step_w(STEPS);

    state_t            state_q, state_d;
    logic [OPC_W-1:0]  op_q, op_d;
    logic [SW-1:0]     step_q, step_d;
    logic              rom_last;
    logic [CW_W-1:0]   rom_word;
    logic              last;
    logic              accept;
    logic              trap_hit;

    ctrl_seq_rom #(
        .OPC_W   (OPC_W),
        .CW_W    (CW_W),
        .STEPS   (STEPS),
        .NUM_OPS (NUM_OPS)
    ) u_rom (
        .op   (op_q),
        .step (step_q),
        .last (rom_last),
        .word (rom_word)
    );

    // The final table slot always terminates, whatever its flag says.
    assign last = rom_last | (step_q == SW'(STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
        end
    end

`ifdef CTRL_SEQ_TRAP_EN
    localparam logic [OPC_W:0] OP_LIMIT = (OPC_W + 1)'(NUM_OPS);

    logic illegal_q;

    assign trap_hit = ({1'b0, opcode} >= OP_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (accept && trap_hit) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign trap_hit = 1'b0;
    assign illegal  = 1'b0;
`endif

    always_comb begin
        instr_ready = (state_q == IDLE) || ((state_q == EXEC) && last && !stall);
        accept      = instr_valid && instr_ready;
        ctrl_valid  = (state_q == EXEC);
        ctrl        = (state_q == EXEC) ? rom_word : '0;
        done        = (state_q == EXEC) && last && !stall;
        step        = step_q;
    end

    // A trapped opcode is still consumed by the handshake, it just never reaches EXEC.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (accept && !trap_hit) begin
                    state_d = EXEC;
                    op_d    = opcode;
                    step_d  = '0;
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (!last) begin
                        step_d = step_q + SW'(1);
                    end else if (accept && !trap_hit) begin
                        op_d   = opcode;
                        step_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer (OPC_W=3 so undefined opcodes are reachable).
// Trap expectations follow CTRL_SEQ_TRAP_EN, matching however the design is built.
module tb_ctrl_sequencer;

    localparam int unsigned OPC_W   = 3;
    localparam int unsigned CW_W    = 8;
    localparam int unsigned STEPS   = 4;
    localparam int unsigned NUM_OPS = 4;

`ifdef CTRL_SEQ_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic             instr_ready;
    logic [OPC_W-1:0] opcode;
    logic             stall;
    logic [CW_W-1:0]  ctrl;
    logic             ctrl_valid;
    logic [1:0]       step;
    logic             done;
    logic             illegal;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] B2B_CTRL  [5] = '{8'hA4, 8'h24, 8'h04, 8'h6A, 8'h2A};
    localparam logic       B2B_DONE  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [1:0] B2B_STEP  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    localparam logic       B2B_RDY   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    localparam logic       STL_STALL [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] STL_CTRL  [6] = '{8'h6A, 8'h6A, 8'h6A, 8'h6A, 8'h2A, 8'h2A};
    localparam logic       STL_DONE  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    ctrl_sequencer #(
        .OPC_W   (OPC_W),
        .CW_W    (CW_W),
        .STEPS   (STEPS),
        .NUM_OPS (NUM_OPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .stall       (stall),
        .ctrl        (ctrl),
        .ctrl_valid  (ctrl_valid),
        .step        (step),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        stall = 1'b0;
        opcode = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", ctrl); end
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL reset_ctrl_valid: got %b want 0", ctrl_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++; if (step !== 2'd0) begin errors++; $display("FAIL reset_step: got %0d want 0", step); end
        rst = 1'b0;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    endtask

    task automatic test_single_step();
        next_cycle();
        instr_valid = 1'b1;
        opcode = 3'd0;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL op0_ready_idle: got %b want 1", instr_ready); end
        next_cycle();
        instr_valid = 1'b0;
        #1;
        checks++; if (ctrl !== 8'hC1) begin errors++; $display("FAIL op0_ctrl: got %h want c1", ctrl); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL op0_done: got %b want 1", done); end
        checks++; if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL op0_valid: got %b want 1", ctrl_valid); end
        next_cycle();
        #1;
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL op0_after_ctrl: got %h want 00", ctrl); end
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL op0_after_valid: got %b want 0", ctrl_valid); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL op0_after_ready: got %b want 1", instr_ready); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        instr_valid = 1'b1;
        opcode = 3'd2;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i < 2) opcode = 3'd3;
            if (i == 2) opcode = 3'd1;
            if (i == 3) instr_valid = 1'b0;
            #1;
            checks++; if (ctrl !== B2B_CTRL[i]) begin errors++; $display("FAIL b2b_ctrl[%0d]: got %h want %h", i, ctrl, B2B_CTRL[i]); end
            checks++; if (done !== B2B_DONE[i]) begin errors++; $display("FAIL b2b_done[%0d]: got %b want %b", i, done, B2B_DONE[i]); end
            checks++; if (step !== B2B_STEP[i]) begin errors++; $display("FAIL b2b_step[%0d]: got %0d want %0d", i, step, B2B_STEP[i]); end
            checks++; if (instr_ready !== B2B_RDY[i]) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, instr_ready, B2B_RDY[i]); end
            checks++; if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, ctrl_valid); end
        end
        next_cycle();
        #1;
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", ctrl_valid); end
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL b2b_end_ctrl: got %h want 00", ctrl); end
    endtask

    task automatic test_stall();
        next_cycle();
        instr_valid = 1'b1;
        opcode = 3'd1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            instr_valid = 1'b0;
            stall = STL_STALL[i];
            #1;
            checks++; if (ctrl !== STL_CTRL[i]) begin errors++; $display("FAIL stall_ctrl[%0d]: got %h want %h", i, ctrl, STL_CTRL[i]); end
            checks++; if (done !== STL_DONE[i]) begin errors++; $display("FAIL stall_done[%0d]: got %b want %b", i, done, STL_DONE[i]); end
            checks++; if (instr_ready !== STL_DONE[i]) begin errors++; $display("FAIL stall_ready[%0d]: got %b want %b", i, instr_ready, STL_DONE[i]); end
        end
        next_cycle();
        stall = 1'b1;
        #1;
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL stall_idle_valid: got %b want 0", ctrl_valid); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL stall_idle_ready: got %b want 1", instr_ready); end
        instr_valid = 1'b1;
        opcode = 3'd3;
        next_cycle();
        instr_valid = 1'b0;
        #1;
        checks++; if (ctrl !== 8'h12) begin errors++; $display("FAIL stall_op3_ctrl: got %h want 12", ctrl); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_op3_done_held: got %b want 0", done); end
        next_cycle();
        stall = 1'b0;
        #1;
        checks++; if (ctrl !== 8'h12) begin errors++; $display("FAIL stall_op3_ctrl2: got %h want 12", ctrl); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_op3_done: got %b want 1", done); end
        next_cycle();
        #1;
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL stall_op3_end: got %b want 0", ctrl_valid); end
    endtask

    task automatic test_reset_abort();
        next_cycle();
        instr_valid = 1'b1;
        opcode = 3'd2;
        next_cycle();
        instr_valid = 1'b0;
        #1;
        checks++; if (ctrl !== 8'hA4) begin errors++; $display("FAIL abort_s0: got %h want a4", ctrl); end
        next_cycle();
        #1;
        checks++; if (ctrl !== 8'h24) begin errors++; $display("FAIL abort_s1: got %h want 24", ctrl); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL abort_ctrl: got %h want 00", ctrl); end
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", ctrl_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        checks++; if (step !== 2'd0) begin errors++; $display("FAIL abort_step: got %0d want 0", step); end
        #1;
        rst = 1'b0;
        next_cycle();
        #1;
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", ctrl_valid); end
        instr_valid = 1'b1;
        opcode = 3'd0;
        next_cycle();
        instr_valid = 1'b0;
        #1;
        checks++; if (ctrl !== 8'hC1) begin errors++; $display("FAIL abort_op0_ctrl: got %h want c1", ctrl); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_op0_done: got %b want 1", done); end
        next_cycle();
    endtask

    task automatic test_trap();
        instr_valid = 1'b1;
        opcode = 3'd5;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL trap_ready: got %b want 1", instr_ready); end
        next_cycle();
        instr_valid = 1'b0;
        #1;
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL trap_ctrl: got %h want 00", ctrl); end
        checks++; if (ctrl_valid !== !TRAP) begin errors++; $display("FAIL trap_valid: got %b want %b", ctrl_valid, !TRAP); end
        checks++; if (done !== !TRAP) begin errors++; $display("FAIL trap_done: got %b want %b", done, !TRAP); end
        checks++; if (illegal !== TRAP) begin errors++; $display("FAIL trap_illegal: got %b want %b", illegal, TRAP); end
        instr_valid = 1'b1;
        opcode = 3'd3;
        next_cycle();
        instr_valid = 1'b0;
        #1;
        checks++; if (ctrl !== 8'h12) begin errors++; $display("FAIL trap_op3_ctrl: got %h want 12", ctrl); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL trap_op3_done: got %b want 1", done); end
        checks++; if (illegal !== TRAP) begin errors++; $display("FAIL trap_sticky1: got %b want %b", illegal, TRAP); end
        next_cycle();
        instr_valid = 1'b1;
        opcode = 3'd1;
        next_cycle();
        next_cycle();
        opcode = 3'd4;
        #1;
        checks++; if (ctrl !== 8'h2A) begin errors++; $display("FAIL trap_b2b_last: got %h want 2a", ctrl); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL trap_b2b_ready: got %b want 1", instr_ready); end
        next_cycle();
        instr_valid = 1'b0;
        #1;
        checks++; if (ctrl_valid !== !TRAP) begin errors++; $display("FAIL trap_b2b_valid: got %b want %b", ctrl_valid, !TRAP); end
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL trap_b2b_ctrl: got %h want 00", ctrl); end
        checks++; if (illegal !== TRAP) begin errors++; $display("FAIL trap_b2b_illegal: got %b want %b", illegal, TRAP); end
        next_cycle();
        #1;
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL trap_end_valid: got %b want 0", ctrl_valid); end
        checks++; if (illegal !== TRAP) begin errors++; $display("FAIL trap_sticky2: got %b want %b", illegal, TRAP); end
        rst = 1'b1;
        #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL trap_rst_clear: got %b want 0", illegal); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_back_to_back();
        test_stall();
        test_reset_abort();
        test_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
